// File: rtl/voice_allocator.sv
// voice_allocator
// ---------------------------------------------------------------------------
// Polyphonic voice allocator. Takes note-on/note-off key events over a
// valid/ready handshake and assigns each note to one of NUM_VOICES sine
// oscillator voices. A note-on first retriggers a voice already sounding the
// same frequency, then takes the lowest free voice, and otherwise steals the
// oldest gated voice. A note-off releases the matching voice and keeps its
// frequency so the oscillator holds pitch through its release.
//
// Each event takes two cycles. The handshake is in IDLE, and the commit is in
// EXEC.
//
// Ports
//   clk           1 MHz system clock
//   rst           asynchronous, active-high reset
//   ev_valid      key event present
//   ev_ready      allocator can accept an event (IDLE and not in reset)
//   ev_on         1 = note-on, 0 = note-off
//   ev_freq       note frequency in Hz; also the note identity
//   all_off       panic level: clears every gate and age at the next edge
//   voice_freq    per-voice frequency, voice v at [v*FREQ_W +: FREQ_W]
//   voice_gate    per-voice "sounding" flag
//   voice_retrig  one-cycle pulse telling an oscillator to restart phase
//   active_count  number of gated voices
//   steal_count   saturating count of voice steals
// ---------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 12,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [FREQ_W-1:0]            ev_freq,
  input  logic                         all_off,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_retrig,
  output logic [3:0]                   active_count,
  output logic [7:0]                   steal_count
);

  localparam int                IDX_W      = $clog2(NUM_VOICES);
  localparam logic [FREQ_W-1:0] RESET_FREQ = FREQ_W'(440);
  localparam logic [AGE_W-1:0]  AGE_MAX    = '1;

  typedef enum logic {IDLE, EXEC} state_e;

  state_e                  state_q, state_d;
  logic                    ev_on_q, ev_on_d;
  logic [FREQ_W-1:0]       ev_freq_q, ev_freq_d;
  logic [FREQ_W-1:0]       freq_q [NUM_VOICES];
  logic [FREQ_W-1:0]       freq_d [NUM_VOICES];
  logic [AGE_W-1:0]        age_q  [NUM_VOICES];
  logic [AGE_W-1:0]        age_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NUM_VOICES-1:0]   retrig_q, retrig_d;
  logic [3:0]              active_q, active_d;
  logic [7:0]              steal_q, steal_d;

  // Voice search results, all taken against the latched event.
  logic                    match_hit, free_hit;
  logic [IDX_W-1:0]        match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]        old_age;

  // Commit decision.
  logic                    commit;
  logic [IDX_W-1:0]        target;

  assign ev_ready = (state_q == IDLE) && !rst;

  // NOTE: every variable written in an always_comb gets a default value
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    old_idx   = '0;
    old_age   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!match_hit && gate_q[v] && (freq_q[v] == ev_freq_q)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(v);
      end
      if (!free_hit && !gate_q[v]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(v);
      end
      // Strictly greater, so ties go to the lowest index.
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_idx = IDX_W'(v);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_freq_d = ev_freq_q;
    freq_d    = freq_q;
    age_d     = age_q;
    gate_d    = gate_q;
    retrig_d  = '0;
    steal_d   = steal_q;
    commit    = 1'b0;
    target    = '0;

    case (state_q)
      IDLE: begin
        if (ev_valid) begin
          state_d   = EXEC;
          ev_on_d   = ev_on;
          ev_freq_d = ev_freq;
        end
      end
      EXEC: begin
        state_d = IDLE;
        // A panic during EXEC consumes the latched event without applying it.
        if (!all_off) begin
          if (ev_on_q) begin
            if (ev_freq_q != '0) begin
              commit = 1'b1;
              if (match_hit) begin
                target = match_idx;
              end else if (free_hit) begin
                target = free_idx;
              end else begin
                target = old_idx;
                if (steal_q != 8'hFF) steal_d = steal_q + 8'd1;
              end
            end
          end else if (match_hit) begin
            gate_d[match_idx] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (gate_q[v] && (IDX_W'(v) != target) && (age_q[v] != AGE_MAX))
          age_d[v] = age_q[v] + 1'b1;
      end
      freq_d[target]   = ev_freq_q;
      gate_d[target]   = 1'b1;
      retrig_d[target] = 1'b1;
      age_d[target]    = '0;
    end

    // Frequencies are kept so that released oscillators hold pitch.
    if (all_off) begin
      gate_d = '0;
      for (int v = 0; v < NUM_VOICES; v++) age_d[v] = '0;
    end

    active_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) active_d = active_d + 4'(gate_d[v]);
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its next value from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ev_on_q   <= 1'b0;
      ev_freq_q <= '0;
      gate_q    <= '0;
      retrig_q  <= '0;
      active_q  <= '0;
      steal_q   <= '0;
      // NOTE: the per-voice arrays are reset on purpose. The oscillators
      // must see a defined 440 Hz and the ages must start equal. The arrays
      // are small, so they are flops rather than RAM.
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v] <= RESET_FREQ;
        age_q[v]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ev_on_q   <= ev_on_d;
      ev_freq_q <= ev_freq_d;
      gate_q    <= gate_d;
      retrig_q  <= retrig_d;
      active_q  <= active_d;
      steal_q   <= steal_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v] <= freq_d[v];
        age_q[v]  <= age_d[v];
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_freq[g*FREQ_W +: FREQ_W] = freq_q[g];
  end

  assign voice_gate   = gate_q;
  assign voice_retrig = retrig_q;
  assign active_count = active_q;
  assign steal_count  = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed bench for voice_allocator with the default parameters: 4 voices,
// 12-bit frequencies and 8-bit ages. Inputs are driven on the falling edge,
// and outputs are sampled on the falling edge.
module tb_voice_allocator;

  logic        clk;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [11:0] ev_freq;
  logic        all_off;
  logic [47:0] voice_freq;
  logic [3:0]  voice_gate;
  logic [3:0]  voice_retrig;
  logic [3:0]  active_count;
  logic [7:0]  steal_count;

  int n_vec = 0;
  int n_err = 0;

  voice_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_freq      (ev_freq),
    .all_off      (all_off),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_retrig (voice_retrig),
    .active_count (active_count),
    .steal_count  (steal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [47:0] pack4(input int f0, input int f1, input int f2, input int f3);
    return {12'(f3), 12'(f2), 12'(f1), 12'(f0)};
  endfunction

  // Full event: handshake, EXEC, then return at the falling edge after the
  // commit edge, when the retrig pulse is visible.
  task automatic do_ev(input logic on, input int f);
    int n;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_freq  = 12'(f);
    n = 0;
    while (!ev_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(n < 20), 64'd1);
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int f [4];
    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_freq  = '0;
    all_off  = 1'b0;
    f[0] = 440; f[1] = 523; f[2] = 659; f[3] = 784;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready",  64'(ev_ready),     64'd0);
    check("rst_freq",   64'(voice_freq),   64'(pack4(440, 440, 440, 440)));
    check("rst_gate",   64'(voice_gate),   64'd0);
    check("rst_retrig", 64'(voice_retrig), 64'd0);
    check("rst_active", 64'(active_count), 64'd0);
    check("rst_steal",  64'(steal_count),  64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(ev_ready), 64'd1);

    // Four back-to-back note-ons with ev_valid held high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready_hi", 64'(ev_ready), 64'd1);
      check("b2b_retrig", 64'(voice_retrig), (i == 0) ? 64'd0 : 64'(1 << (i - 1)));
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_freq  = 12'(f[i]);
      @(negedge clk);
      check("b2b_ready_lo", 64'(ev_ready), 64'd0);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    check("fill_retrig", 64'(voice_retrig), 64'h8);
    check("fill_freq",   64'(voice_freq),   64'(pack4(440, 523, 659, 784)));
    check("fill_gate",   64'(voice_gate),   64'hF);
    check("fill_active", 64'(active_count), 64'd4);

    // Full allocator: 880 steals voice 0, the oldest voice at age 3
    do_ev(1'b1, 880);
    check("steal_retrig", 64'(voice_retrig), 64'h1);
    check("steal_freq",   64'(voice_freq),   64'(pack4(880, 523, 659, 784)));
    check("steal_count",  64'(steal_count),  64'd1);
    check("steal_gate",   64'(voice_gate),   64'hF);

    // 523 is already sounding on voice 1, so that voice is retriggered
    do_ev(1'b1, 523);
    check("retrig_retrig", 64'(voice_retrig), 64'h2);
    check("retrig_freq",   64'(voice_freq),   64'(pack4(880, 523, 659, 784)));
    check("retrig_steal",  64'(steal_count),  64'd1);

    // Note-off 659 releases voice 2 and keeps its frequency
    do_ev(1'b0, 659);
    check("off_gate",   64'(voice_gate),   64'hB);
    check("off_active", 64'(active_count), 64'd3);
    check("off_freq",   64'(voice_freq),   64'(pack4(880, 523, 659, 784)));
    check("off_retrig", 64'(voice_retrig), 64'd0);

    // The free voice 2 takes the next note-on
    do_ev(1'b1, 1000);
    check("free_retrig", 64'(voice_retrig), 64'h4);
    check("free_freq",   64'(voice_freq),   64'(pack4(880, 523, 1000, 784)));
    check("free_gate",   64'(voice_gate),   64'hF);
    check("free_steal",  64'(steal_count),  64'd1);

    // A note-off with no matching voice changes nothing
    do_ev(1'b0, 123);
    check("nomatch_gate", 64'(voice_gate), 64'hF);
    check("nomatch_freq", 64'(voice_freq), 64'(pack4(880, 523, 1000, 784)));

    // A note-on with frequency 0 is dropped
    do_ev(1'b1, 0);
    check("zero_retrig", 64'(voice_retrig), 64'd0);
    check("zero_freq",   64'(voice_freq),   64'(pack4(880, 523, 1000, 784)));
    check("zero_active", 64'(active_count), 64'd4);

    // Ages are now v0=2, v1=1, v3=3, so 200 steals voice 3
    do_ev(1'b1, 200);
    check("age_retrig", 64'(voice_retrig), 64'h8);
    check("age_freq",   64'(voice_freq),   64'(pack4(880, 523, 1000, 200)));
    check("age_steal",  64'(steal_count),  64'd2);

    // all_off during the EXEC cycle of note-on 700
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_freq  = 12'd700;
    @(negedge clk);
    ev_valid = 1'b0;
    all_off  = 1'b1;
    @(negedge clk);
    all_off  = 1'b0;
    check("panic_gate",   64'(voice_gate),   64'd0);
    check("panic_active", 64'(active_count), 64'd0);
    check("panic_freq",   64'(voice_freq),   64'(pack4(880, 523, 1000, 200)));
    check("panic_retrig", 64'(voice_retrig), 64'd0);
    check("panic_steal",  64'(steal_count),  64'd2);

    // After the panic, the next note-on lands on voice 0
    do_ev(1'b1, 300);
    check("post_panic_retrig", 64'(voice_retrig), 64'h1);
    check("post_panic_freq",   64'(voice_freq),   64'(pack4(300, 523, 1000, 200)));
    check("post_panic_active", 64'(active_count), 64'd1);

    // Reset asserted during EXEC
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_freq  = 12'd500;
    @(negedge clk);
    ev_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_rst_ready",  64'(ev_ready),     64'd0);
    check("mid_rst_freq",   64'(voice_freq),   64'(pack4(440, 440, 440, 440)));
    check("mid_rst_gate",   64'(voice_gate),   64'd0);
    check("mid_rst_retrig", 64'(voice_retrig), 64'd0);
    check("mid_rst_active", 64'(active_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 264 note-ons: 4 fill the voices and 260 are steals
    for (int k = 1; k <= 264; k++) begin
      do_ev(1'b1, k);
      if (k == 258) check("steal_254", 64'(steal_count), 64'd254);
    end
    check("steal_sat",  64'(steal_count), 64'd255);
    check("rr_freq",    64'(voice_freq),  64'(pack4(261, 262, 263, 264)));
    check("rr_gate",    64'(voice_gate),  64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator for the synthesiser. It accepts note-on/note-off key events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` sine oscillator voices. Each voice has a frequency, a gate and a one-cycle retrigger pulse. When every voice is busy, the allocator steals the oldest one. It sits between the key/MIDI front end and the bank of sine oscillators, and drives each oscillator's 12-bit frequency input.

## Interface
- `NUM_VOICES`, default 4: number of oscillator voices. Legal range is 2..8.
- `FREQ_W`, default 12: frequency width in Hz. Matches the oscillator `freq` input.
- `AGE_W`, default 8: width of the per-voice age counter. The counter saturates.
- `clk`  in  1: 1 MHz system clock. Single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `ev_valid`  in  1: event present.
- `ev_ready`  out  1: allocator can accept an event.
- `ev_on`  in  1: 1 = note-on, 0 = note-off.
- `ev_freq`  in  FREQ_W: note frequency in Hz. Also serves as the note identity.
- `all_off`  in  1: panic. Synchronous level; clears all gates.
- `voice_freq`  out  NUM_VOICES*FREQ_W: per-voice frequency. Voice v occupies bits [v*FREQ_W +: FREQ_W].
- `voice_gate`  out  NUM_VOICES: voice sounding.
- `voice_retrig`  out  NUM_VOICES: one-cycle pulse telling the oscillator to restart phase.
- `active_count`  out  4: number of gated voices.
- `steal_count`  out  8: saturating count of steals.

## Operation
**State machine**
- Two states: IDLE and EXEC. `ev_ready` = (state == IDLE) and !`rst`.
- IDLE: when `ev_valid` & `ev_ready`, latch `ev_on`/`ev_freq` and go to EXEC.
- EXEC: perform the commit below and return to IDLE unconditionally.

**Note-on commit**, in priority order:
1. `ev_freq` == 0: drop the event. No state changes.
2. A gated voice already has `voice_freq` == `ev_freq`: retrigger that voice. Pulse its `voice_retrig`, clear its age, keep the gate at 1.
3. Otherwise, take the lowest-index voice with gate = 0. Load the frequency, set gate = 1, pulse retrig, clear age.
4. Otherwise (all voices gated), steal the voice with maximum age. Ties go to the lowest index. Load the frequency, keep the gate at 1, pulse retrig, clear age, and increment `steal_count` (saturates at 255).

**Ages**
- On every committed note-on (cases 2–4), each gated voice other than the target increments its age, saturating at 2^AGE_W−1.

**Note-off commit**
- The gated voice whose freq equals `ev_freq` sets gate = 0. Its freq and age are retained, so the oscillator keeps its frequency through release.
- No match: the event is consumed with no effect.
- Note-off never pulses retrig.

**Invariants**
- At most one gated voice holds a given frequency.
- `active_count` = popcount(`voice_gate`), registered and updated in the same cycle as the gates.

**`all_off`**
- Sampled every cycle. It takes priority over EXEC.
- When high, all gates go to 0 at the next edge and all ages go to 0.
- A latched event in EXEC is discarded (consumed, not applied), and the state goes to IDLE.
- `all_off` does not block acceptance in IDLE. An accepted event is discarded if `all_off` is still high during its EXEC cycle.

## Timing
**Reset values** (held while `rst` is high)
- `voice_freq` = 440 for every voice.
- `voice_gate` = 0, `voice_retrig` = 0, `active_count` = 0, `steal_count` = 0.
- Ages = 0, state = IDLE, `ev_ready` = 0.

**Reset mid-operation**
- Asserting `rst` while in EXEC abandons the event. No partial update is visible.

**Event timing**
- Event handshake completes at edge E0. EXEC occupies the cycle after E0.
- `voice_freq`, `voice_gate`, ages and counts update at edge E1.
- `voice_retrig` is high for exactly the cycle between E1 and E2.
- `ev_ready` is low for the EXEC cycle and high again after E1.
- Maximum throughput is one event per 2 cycles. Latency from acceptance to outputs is 1 cycle.

**Input and output registering**
- `ev_freq`/`ev_on` are ignored when not handshaken. They may change freely while `ev_ready` = 0.
- All outputs are registered except `ev_ready`.

## Test plan
- Reset, then note-on 440, 523, 659, 784 back-to-back (`ev_valid` held high). Expect voices 0..3 = 440/523/659/784, gates 1111, `active_count` 4, one retrig per voice, `ev_ready` toggling 1/0.
- With 4 voices full, note-on 880. Expect voice 0 (oldest, age 3) stolen: freq 880, retrig on voice 0 only, `steal_count` 1, gates stay 1111.
- Note-on 523 while 523 is already gated on voice 1. Expect retrig on voice 1, no new allocation, voice 1 age 0, other gated ages +1.
- Note-off 659 gated on voice 2. Expect gate 2 = 0, freq 659 retained, `active_count` 3. A following note-on 1000 lands on voice 2. A note-off for 123 (no match) changes nothing.
- Note-on with freq 0 is dropped with no change. `all_off` asserted in the EXEC cycle of a note-on 700 clears all gates, and voice freqs do not become 700.
- Assert `rst` in EXEC. All outputs take reset values at once and `voice_freq` = 440 everywhere. 260 forced steals saturate `steal_count` at 255.
